// File: rtl/lcd_driver_pkg.sv
// Shared timing defaults, RGB565 colour constants and FSM state type for the LCD timing generator.
package lcd_driver_pkg;

  localparam int unsigned CNT_W  = 11;
  localparam int unsigned RGB_W  = 16;
  localparam int unsigned FCNT_W = 4;

  // Default 480x272 panel timing
  localparam int unsigned H_SYNC_DEF      = 41;
  localparam int unsigned H_BACK_DEF      = 2;
  localparam int unsigned H_DISP_DEF      = 480;
  localparam int unsigned H_TOTAL_DEF     = 525;
  localparam int unsigned V_SYNC_DEF      = 10;
  localparam int unsigned V_BACK_DEF      = 2;
  localparam int unsigned V_DISP_DEF      = 272;
  localparam int unsigned V_TOTAL_DEF     = 286;
  localparam int unsigned WARM_FRAMES_DEF = 2;

  // RGB565 colours used by the colour-bar pattern
  localparam logic [RGB_W-1:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [RGB_W-1:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [RGB_W-1:0] RGB_CYAN    = 16'h07FF;
  localparam logic [RGB_W-1:0] RGB_GREEN   = 16'h07E0;
  localparam logic [RGB_W-1:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [RGB_W-1:0] RGB_RED     = 16'hF800;
  localparam logic [RGB_W-1:0] RGB_BLUE    = 16'h001F;
  localparam logic [RGB_W-1:0] RGB_BLACK   = 16'h0000;

  typedef enum logic {
    ST_WARM = 1'b0,
    ST_RUN  = 1'b1
  } lcd_state_e;

  // Bar index (0 = leftmost) to colour
  function automatic logic [RGB_W-1:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = RGB_WHITE;
      3'd1:    bar_color = RGB_YELLOW;
      3'd2:    bar_color = RGB_CYAN;
      3'd3:    bar_color = RGB_GREEN;
      3'd4:    bar_color = RGB_MAGENTA;
      3'd5:    bar_color = RGB_RED;
      3'd6:    bar_color = RGB_BLUE;
      default: bar_color = RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/lcd_driver_if.sv
// Pixel request bus between the timing generator (master) and the pixel source (slave).
interface lcd_driver_if;
  import lcd_driver_pkg::*;

  logic [CNT_W-1:0] pixel_xpos;
  logic [CNT_W-1:0] pixel_ypos;
  logic [RGB_W-1:0] pixel_data;

  modport master (output pixel_xpos, output pixel_ypos, input pixel_data);
  modport slave  (input pixel_xpos, input pixel_ypos, output pixel_data);
endinterface

// File: rtl/lcd_driver_sync_counter.sv
// Free-running horizontal/vertical scan counters with end-of-line and end-of-frame pulses.
module lcd_driver_sync_counter
  import lcd_driver_pkg::*;
#(
  parameter int unsigned H_TOTAL = H_TOTAL_DEF,
  parameter int unsigned V_TOTAL = V_TOTAL_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] h_cnt_o,
  output logic [CNT_W-1:0] v_cnt_o,
  output logic             h_wrap_c_o,
  output logic             v_wrap_c_o
);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

  assign h_wrap_c_o = (h_cnt_q == CNT_W'(H_TOTAL - 1));
  assign v_wrap_c_o = h_wrap_c_o && (v_cnt_q == CNT_W'(V_TOTAL - 1));
  assign h_cnt_o    = h_cnt_q;
  assign v_cnt_o    = v_cnt_q;

  // Next count: h always advances, v advances on h wrap
  always_comb begin
    h_cnt_d = h_cnt_q + CNT_W'(1);
    v_cnt_d = v_cnt_q;
    if (h_wrap_c_o) begin
      h_cnt_d = '0;
      v_cnt_d = v_wrap_c_o ? '0 : v_cnt_q + CNT_W'(1);
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

endmodule

// File: rtl/lcd_driver.sv
// RGB-interface LCD timing generator: scans the panel, requests pixels one cycle ahead of DE,
// and holds DE/backlight off for a number of warm-up frames after reset.
// Optional build macro LCD_DRIVER_COLORBAR_EN adds test_pat_en and an 8-bar colour pattern.
module lcd_driver
  import lcd_driver_pkg::*;
#(
  parameter int unsigned H_SYNC      = H_SYNC_DEF,
  parameter int unsigned H_BACK      = H_BACK_DEF,
  parameter int unsigned H_DISP      = H_DISP_DEF,
  parameter int unsigned H_TOTAL     = H_TOTAL_DEF,
  parameter int unsigned V_SYNC      = V_SYNC_DEF,
  parameter int unsigned V_BACK      = V_BACK_DEF,
  parameter int unsigned V_DISP      = V_DISP_DEF,
  parameter int unsigned V_TOTAL     = V_TOTAL_DEF,
  parameter int unsigned WARM_FRAMES = WARM_FRAMES_DEF
) (
  input  logic             lcd_clk,
  input  logic             sys_rst_n,
  lcd_driver_if.master     pix,
`ifdef LCD_DRIVER_COLORBAR_EN
  input  logic             test_pat_en,
`endif
  output logic             lcd_hs,
  output logic             lcd_vs,
  output logic             lcd_de,
  output logic [RGB_W-1:0] lcd_rgb,
  output logic             lcd_bl,
  output logic             frame_start
);

  localparam int unsigned H_ACT_S = H_SYNC + H_BACK;
  localparam int unsigned H_ACT_E = H_ACT_S + H_DISP;
  localparam int unsigned V_ACT_S = V_SYNC + V_BACK;
  localparam int unsigned V_ACT_E = V_ACT_S + V_DISP;

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_wrap_c, v_wrap_c;
  logic             v_act_c, req_c;

  lcd_state_e        state_q, state_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic lcd_hs_q, lcd_vs_q, lcd_de_q, lcd_bl_q, frame_start_q;

  lcd_driver_sync_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_cnt (
    .clk        (lcd_clk),
    .rst_n      (sys_rst_n),
    .h_cnt_o    (h_cnt),
    .v_cnt_o    (v_cnt),
    .h_wrap_c_o (h_wrap_c),
    .v_wrap_c_o (v_wrap_c)
  );

  // Pixel request window leads the active window by one clock
  assign v_act_c = (v_cnt >= CNT_W'(V_ACT_S)) && (v_cnt < CNT_W'(V_ACT_E));
  assign req_c   = v_act_c && (h_cnt >= CNT_W'(H_ACT_S - 1)) && (h_cnt < CNT_W'(H_ACT_E - 1));

  assign pix.pixel_xpos = req_c ? (h_cnt - CNT_W'(H_ACT_S - 2)) : '0;
  assign pix.pixel_ypos = req_c ? (v_cnt - CNT_W'(V_ACT_S - 1)) : '0;

  // Warm-up FSM: count completed frames, then enable DE and backlight for good
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_WARM: begin
        if (v_wrap_c) begin
          if (frame_cnt_q == FCNT_W'(WARM_FRAMES - 1)) begin
            state_d = ST_RUN;
          end else begin
            frame_cnt_d = frame_cnt_q + FCNT_W'(1);
          end
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_WARM;
    endcase
  end

  // FSM state register
  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_WARM;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Panel controls: one clock behind the counters, so DE lines up with pixel_data
  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lcd_hs_q      <= 1'b1;
      lcd_vs_q      <= 1'b1;
      lcd_de_q      <= 1'b0;
      lcd_bl_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      lcd_hs_q      <= ~(h_cnt < CNT_W'(H_SYNC));
      lcd_vs_q      <= ~(v_cnt < CNT_W'(V_SYNC));
      lcd_de_q      <= req_c && (state_q == ST_RUN);
      lcd_bl_q      <= (state_q == ST_RUN);
      frame_start_q <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

  assign lcd_hs      = lcd_hs_q;
  assign lcd_vs      = lcd_vs_q;
  assign lcd_de      = lcd_de_q;
  assign lcd_bl      = lcd_bl_q;
  assign frame_start = frame_start_q;

`ifdef LCD_DRIVER_COLORBAR_EN
  localparam int unsigned BAR_W = H_DISP / 8;

  logic [CNT_W-1:0] bar_div_c;
  logic [2:0]       bar_idx_c;
  logic [RGB_W-1:0] bar_rgb_q;

  // Bar index of the requested column; the last bar absorbs any remainder
  assign bar_div_c = (pix.pixel_xpos - CNT_W'(1)) / CNT_W'(BAR_W);
  assign bar_idx_c = (bar_div_c > CNT_W'(7)) ? 3'd7 : 3'(bar_div_c);

  // Pattern colour registered alongside DE
  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bar_rgb_q <= '0;
    end else begin
      bar_rgb_q <= bar_color(bar_idx_c);
    end
  end

  assign lcd_rgb = lcd_de_q ? (test_pat_en ? bar_rgb_q : pix.pixel_data) : '0;
`else
  assign lcd_rgb = lcd_de_q ? pix.pixel_data : '0;
`endif

endmodule

// File: tb/tb_lcd_driver.sv
// Directed bench for lcd_driver: full horizontal timing, shortened vertical timing (10 lines/frame).
module tb_lcd_driver;
  import lcd_driver_pkg::*;

  localparam int unsigned TB_V_SYNC  = 2;
  localparam int unsigned TB_V_BACK  = 2;
  localparam int unsigned TB_V_DISP  = 4;
  localparam int unsigned TB_V_TOTAL = 10;
  localparam int unsigned LINE       = 525;
  localparam int unsigned FR         = LINE * TB_V_TOTAL;

  logic             clk;
  logic             rst_n;
  logic             test_pat_en;
  logic             lcd_hs, lcd_vs, lcd_de, lcd_bl, frame_start;
  logic [RGB_W-1:0] lcd_rgb;

  lcd_driver_if pix_if ();

  lcd_driver #(
    .V_SYNC  (TB_V_SYNC),
    .V_BACK  (TB_V_BACK),
    .V_DISP  (TB_V_DISP),
    .V_TOTAL (TB_V_TOTAL)
  ) dut (
    .lcd_clk     (clk),
    .sys_rst_n   (rst_n),
    .pix         (pix_if),
`ifdef LCD_DRIVER_COLORBAR_EN
    .test_pat_en (test_pat_en),
`endif
    .lcd_hs      (lcd_hs),
    .lcd_vs      (lcd_vs),
    .lcd_de      (lcd_de),
    .lcd_rgb     (lcd_rgb),
    .lcd_bl      (lcd_bl),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pixel source: registered {xpos[4:0], ypos[10:0]}
  always @(posedge clk) begin
    pix_if.pixel_data <= {pix_if.pixel_xpos[4:0], pix_if.pixel_ypos[10:0]};
  end

  // Clocks since reset release
  int unsigned cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Output monitor over the first three frames after release
  logic        hs_prev, vs_prev, de_prev;
  int unsigned hs_run, hs_low_len, hs_nf;
  int unsigned vs_run, vs_low_len, vs_nf;
  int unsigned hs_fall [2];
  int unsigned vs_fall [2];
  int unsigned de_run, de_run_min, de_run_max, fs_cnt;
  int unsigned de_cnt [3];
  int unsigned de_rise [3];
  int unsigned bl_cnt [3];

  always @(negedge clk) begin
    if (!rst_n) begin
      hs_prev = 1'b1; vs_prev = 1'b1; de_prev = 1'b0;
      hs_run = 0; hs_low_len = 0; hs_nf = 0;
      vs_run = 0; vs_low_len = 0; vs_nf = 0;
      de_run = 0; de_run_min = 32'hFFFF; de_run_max = 0; fs_cnt = 0;
      for (int i = 0; i < 2; i++) begin hs_fall[i] = 0; vs_fall[i] = 0; end
      for (int i = 0; i < 3; i++) begin de_cnt[i] = 0; de_rise[i] = 0; bl_cnt[i] = 0; end
    end else if (cyc >= 1 && cyc <= 3 * FR) begin
      int unsigned fi;
      fi = (cyc - 1) / FR;
      if (hs_prev && !lcd_hs && hs_nf < 2) begin hs_fall[hs_nf] = cyc; hs_nf++; end
      if (!lcd_hs) hs_run++;
      if (!hs_prev && lcd_hs) begin hs_low_len = hs_run; hs_run = 0; end
      if (vs_prev && !lcd_vs && vs_nf < 2) begin vs_fall[vs_nf] = cyc; vs_nf++; end
      if (!lcd_vs) vs_run++;
      if (!vs_prev && lcd_vs) begin vs_low_len = vs_run; vs_run = 0; end
      if (lcd_de) begin de_cnt[fi]++; de_run++; end
      if (lcd_de && !de_prev) de_rise[fi]++;
      if (!lcd_de && de_prev) begin
        if (de_run < de_run_min) de_run_min = de_run;
        if (de_run > de_run_max) de_run_max = de_run;
        de_run = 0;
      end
      if (lcd_bl) bl_cnt[fi]++;
      if (frame_start) fs_cnt++;
      hs_prev = lcd_hs; vs_prev = lcd_vs; de_prev = lcd_de;
    end
  end

  int unsigned n_total  = 0;
  int unsigned n_passed = 0;
  int unsigned n_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_passed++;
    else begin
      n_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the falling edge at which cyc == n
  task automatic goto(input int unsigned n);
    int unsigned guard;
    guard = 0;
    while (cyc != n) begin
      @(negedge clk);
      guard++;
      if (guard > 40000) begin
        $display("FAIL goto: cycle %0d not reached (at %0d)", n, cyc);
        $fatal(1, "timeout");
      end
    end
  endtask

  task automatic check_stats(input string run);
    check({run, " hs_low"},    hs_low_len, 41);
    check({run, " hs_period"}, hs_fall[1] - hs_fall[0], LINE);
    check({run, " vs_low"},    vs_low_len, 2 * LINE);
    check({run, " vs_period"}, vs_fall[1] - vs_fall[0], FR);
    check({run, " de_f0"},     de_cnt[0], 0);
    check({run, " de_f1"},     de_cnt[1], 0);
    check({run, " bl_f01"},    bl_cnt[0] + bl_cnt[1], 0);
    check({run, " bl_f2"},     bl_cnt[2], FR);
    check({run, " de_f2"},     de_cnt[2], 480 * TB_V_DISP);
    check({run, " de_lines"},  de_rise[2], TB_V_DISP);
    check({run, " de_runmin"}, de_run_min, 480);
    check({run, " de_runmax"}, de_run_max, 480);
    check({run, " fs_count"},  fs_cnt, 3);
  endtask

  // First active request of frame 2: h=42, v=4 -> counter value 2*FR + 4*LINE + 42
  localparam int unsigned REQ1 = 2 * FR + 4 * LINE + 42;

  initial begin
    rst_n = 1'b0;
    test_pat_en = 1'b0;

    // Reset values
    repeat (10) @(negedge clk);
    check("rst hs", lcd_hs, 1);
    check("rst vs", lcd_vs, 1);
    check("rst de", lcd_de, 0);
    check("rst rgb", lcd_rgb, 0);
    check("rst bl", lcd_bl, 0);
    check("rst xpos", pix_if.pixel_xpos, 0);
    check("rst ypos", pix_if.pixel_ypos, 0);
    check("rst fs", frame_start, 0);
    rst_n = 1'b1;

    goto(1);
    check("fs cyc1", frame_start, 1);
    goto(2);
    check("fs cyc2", frame_start, 0);

    // Request/DE alignment on the first visible line
    goto(REQ1);
    check("req1 xpos", pix_if.pixel_xpos, 1);
    check("req1 ypos", pix_if.pixel_ypos, 1);
    check("req1 de_pre", lcd_de, 0);
    goto(REQ1 + 1);
    check("de1 rise", lcd_de, 1);
    check("de1 rgb", lcd_rgb, 16'h0801);
    goto(REQ1 + 479);
    check("req480 xpos", pix_if.pixel_xpos, 480);
    goto(REQ1 + 480);
    check("de480", lcd_de, 1);
    check("de480 rgb", lcd_rgb, 16'h0001);
    check("req_end xpos", pix_if.pixel_xpos, 0);
    goto(REQ1 + 481);
    check("de_end", lcd_de, 0);
    check("de_end rgb", lcd_rgb, 0);

    goto(3 * FR + 1);
    check_stats("run1");

    // Reset in the middle of an active line of frame 3 (column 58)
    goto(REQ1 + FR + 58);
    check("mid de", lcd_de, 1);
    check("mid rgb", lcd_rgb, 16'hD001);
    #2 rst_n = 1'b0;
    #1;
    check("arst de", lcd_de, 0);
    check("arst rgb", lcd_rgb, 0);
    check("arst bl", lcd_bl, 0);
    check("arst xpos", pix_if.pixel_xpos, 0);
    check("arst ypos", pix_if.pixel_ypos, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;

    // Second run: warm-up repeats; colour bars (when built in) on first visible line
    goto(REQ1);
    test_pat_en = 1'b1;
    goto(REQ1 + 1);
`ifdef LCD_DRIVER_COLORBAR_EN
    check("bar col1", lcd_rgb, 16'hFFFF);
`else
    check("pix col1", lcd_rgb, 16'h0801);
`endif
    goto(REQ1 + 61);
`ifdef LCD_DRIVER_COLORBAR_EN
    check("bar col61", lcd_rgb, 16'hFFE0);
`else
    check("pix col61", lcd_rgb, 16'hE801);
`endif
    goto(REQ1 + 480);
`ifdef LCD_DRIVER_COLORBAR_EN
    check("bar col480", lcd_rgb, 16'h0000);
`else
    check("pix col480", lcd_rgb, 16'h0001);
`endif
    test_pat_en = 1'b0;
    goto(REQ1 + LINE + 1);
    check("line2 col1", lcd_rgb, 16'h0802);

    goto(3 * FR + 1);
    check_stats("run2");

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
